// File: rtl/calc1_port_driver.sv
// rtl/calc1_port_driver.sv - calc1 command-port driver: transaction FIFO, two-beat request, response capture.
module calc1_port_driver #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        txn_valid,
  output logic        txn_ready,
  input  logic [0:3]  txn_cmd,
  input  logic [0:31] txn_op1,
  input  logic [0:31] txn_op2,
  output logic [0:3]  req_cmd_out,
  output logic [0:31] req_data_out,
  input  logic [0:1]  out_resp,
  input  logic [0:31] out_data,
  output logic        rsp_valid,
  output logic [0:3]  rsp_cmd,
  output logic [0:1]  rsp_resp,
  output logic [0:31] rsp_data,
  output logic        rsp_timeout,
  output logic        stray_resp,
  output logic        busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, CMD, DATA, WAIT, REPORT} state_t;

  state_t        state_q;
  logic [0:3]    mem_cmd [DEPTH];
  logic [0:31]   mem_op1 [DEPTH];
  logic [0:31]   mem_op2 [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [0:3]    hold_cmd_q;
  logic [0:31]   hold_op2_q;
  logic [CW-1:0] tmo_cnt_q;
  logic          push, pop;

  assign txn_ready = (count_q != (AW+1)'(DEPTH));
  // Zero-command transfers still handshake but never enter the FIFO.
  assign push      = txn_valid && txn_ready && (txn_cmd != 4'd0);
  assign pop       = (state_q == IDLE) && (count_q != '0);
  assign busy      = (state_q != IDLE) || (count_q != '0);
  assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge c_clk) begin
    if (push) begin
      mem_cmd[wr_ptr_q] <= txn_cmd;
      mem_op1[wr_ptr_q] <= txn_op1;
      mem_op2[wr_ptr_q] <= txn_op2;
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      hold_cmd_q   <= '0;
      hold_op2_q   <= '0;
      tmo_cnt_q    <= '0;
      req_cmd_out  <= '0;
      req_data_out <= '0;
      rsp_valid    <= 1'b0;
      rsp_cmd      <= '0;
      rsp_resp     <= '0;
      rsp_data     <= '0;
      rsp_timeout  <= 1'b0;
      stray_resp   <= 1'b0;
    end else begin
      stray_resp <= (state_q != WAIT) && (out_resp != 2'd0);
      rsp_valid  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            hold_cmd_q   <= mem_cmd[rd_ptr_q];
            hold_op2_q   <= mem_op2[rd_ptr_q];
            req_cmd_out  <= mem_cmd[rd_ptr_q];
            req_data_out <= mem_op1[rd_ptr_q];
            state_q      <= CMD;
          end
        end
        CMD: begin
          req_cmd_out  <= '0;
          req_data_out <= hold_op2_q;
          state_q      <= DATA;
        end
        DATA: begin
          req_data_out <= '0;
          tmo_cnt_q    <= '0;
          state_q      <= WAIT;
        end
        WAIT: begin
          if (out_resp != 2'd0) begin
            rsp_valid   <= 1'b1;
            rsp_cmd     <= hold_cmd_q;
            rsp_resp    <= out_resp;
            rsp_data    <= out_data;
            rsp_timeout <= 1'b0;
            state_q     <= REPORT;
          end else if (tmo_cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_valid   <= 1'b1;
            rsp_cmd     <= hold_cmd_q;
            rsp_resp    <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
            state_q     <= REPORT;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
          end
        end
        REPORT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_calc1_port_driver.sv
// tb/tb_calc1_port_driver.sv - directed and random checks of calc1_port_driver against a transaction-level model.
module tb_calc1_port_driver;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int SILENT  = 99;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic        txn_valid;
  logic        txn_ready;
  logic [0:3]  txn_cmd;
  logic [0:31] txn_op1, txn_op2;
  logic [0:3]  req_cmd_out;
  logic [0:31] req_data_out;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        rsp_valid;
  logic [0:3]  rsp_cmd;
  logic [0:1]  rsp_resp;
  logic [0:31] rsp_data;
  logic        rsp_timeout;
  logic        stray_resp;
  logic        busy;

  always #5 c_clk = ~c_clk;

  calc1_port_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .c_clk(c_clk), .reset(reset),
    .txn_valid(txn_valid), .txn_ready(txn_ready),
    .txn_cmd(txn_cmd), .txn_op1(txn_op1), .txn_op2(txn_op2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .out_resp(out_resp), .out_data(out_data),
    .rsp_valid(rsp_valid), .rsp_cmd(rsp_cmd), .rsp_resp(rsp_resp),
    .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .stray_resp(stray_resp), .busy(busy)
  );

  typedef struct {
    logic [0:3]  cmd;
    logic [0:31] op1;
    logic [0:31] op2;
    logic [0:1]  resp;
    logic [0:31] data;
    int          delay;
    bit          stray;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  int   phase = 0;
  int   k = 0;
  int   rpt_cnt = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus-level responder and scoreboard, evaluated once per falling edge.
  task automatic monitor();
    if (!reset) begin
      phase = 0; k = 0; exp_q.delete(); out_resp = '0; out_data = '0;
      return;
    end
    case (phase)
      0: begin
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_stray", stray_resp, 0);
        if (req_cmd_out != 4'd0) begin
          if (exp_q.size() == 0) chk("unexpected_cmd", req_cmd_out, 0);
          else begin
            cur = exp_q.pop_front();
            chk("cmd_beat_cmd", req_cmd_out, cur.cmd);
            chk("cmd_beat_op1", req_data_out, cur.op1);
            out_resp = cur.stray ? 2'd2 : 2'd0;
            phase = 1;
          end
        end else chk("idle_bus_data", req_data_out, 0);
      end
      1: begin
        chk("data_beat_cmd", req_cmd_out, 0);
        chk("data_beat_op2", req_data_out, cur.op2);
        chk("data_beat_rsp_valid", rsp_valid, 0);
        chk("cmd_stray", stray_resp, cur.stray);
        out_resp = '0;
        phase = 2; k = 0;
      end
      default: begin
        if (k > 0 && k - 1 == cur.delay) begin
          chk("rsp_valid", rsp_valid, 1);
          chk("rsp_cmd", rsp_cmd, cur.cmd);
          chk("rsp_resp", rsp_resp, cur.resp);
          chk("rsp_data", rsp_data, cur.data);
          chk("rsp_timeout", rsp_timeout, 0);
          out_resp = '0; out_data = '0;
          rpt_cnt++; phase = 0;
        end else if (k == TIMEOUT) begin
          chk("tmo_valid", rsp_valid, 1);
          chk("tmo_cmd", rsp_cmd, cur.cmd);
          chk("tmo_resp", rsp_resp, 0);
          chk("tmo_data", rsp_data, 0);
          chk("tmo_flag", rsp_timeout, 1);
          rpt_cnt++; phase = 0;
        end else begin
          chk("wait_rsp_valid", rsp_valid, 0);
          chk("wait_bus_cmd", req_cmd_out, 0);
          chk("wait_bus_data", req_data_out, 0);
          chk("wait_stray", stray_resp, 0);
          if (k == cur.delay) begin
            out_resp = cur.resp; out_data = cur.data;
          end else out_resp = '0;
          k++;
        end
      end
    endcase
  endtask

  task automatic step();
    @(negedge c_clk);
    monitor();
  endtask

  task automatic push(input logic [0:3] cmd, input logic [0:31] a, input logic [0:31] b,
                      input logic [0:1] r, input logic [0:31] d, input int dly, input bit s);
    int g = 0;
    txn_t t;
    txn_valid = 1'b1; txn_cmd = cmd; txn_op1 = a; txn_op2 = b;
    while (!txn_ready && g < 300) begin step(); g++; end
    chk("push_ready_bound", g < 300, 1);
    if (cmd != 4'd0) begin
      t.cmd = cmd; t.op1 = a; t.op2 = b; t.resp = r; t.data = d; t.delay = dly; t.stray = s;
      exp_q.push_back(t);
    end
    step();
    txn_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || phase != 0 || busy) && g < 600) begin step(); g++; end
    chk("drain_bound", g < 600, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, txn_ready, 1);
    chk({tag, "_req_cmd"}, req_cmd_out, 0);
    chk({tag, "_req_data"}, req_data_out, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_cmd"}, rsp_cmd, 0);
    chk({tag, "_rsp_resp"}, rsp_resp, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_stray"}, stray_resp, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int base;
    int g;
    logic [0:3] c;
    int dly;
    txn_valid = 1'b0; txn_cmd = '0; txn_op1 = '0; txn_op2 = '0;
    out_resp = '0; out_data = '0;
    step(); step();
    chk_reset_outputs("reset");
    reset = 1'b1;
    step();
    chk_reset_outputs("post_reset");

    // Single ADD answered on the third WAIT cycle
    push(4'd1, 32'd5, 32'd7, 2'd1, 32'd12, 2, 1'b0);
    drain();
    chk("add_reports", rpt_cnt, 1);

    // Fill the FIFO behind an in-flight transaction
    base = rpt_cnt;
    for (int i = 0; i <= DEPTH; i++)
      push(4'(i + 1), $urandom, $urandom, 2'($urandom_range(1, 3)), $urandom, 4, 1'b0);
    chk("fill_ready_low", txn_ready, 0);
    chk("fill_busy", busy, 1);
    drain();
    chk("fill_reports", rpt_cnt - base, DEPTH + 1);

    // Silent responder, then a normal transaction
    push(4'd3, $urandom, $urandom, 2'd1, 32'd0, SILENT, 1'b0);
    push(4'd4, $urandom, $urandom, 2'd3, $urandom, 1, 1'b0);
    drain();

    // cmd=0 between two SUBs
    base = rpt_cnt;
    push(4'd2, 32'd20, 32'd3, 2'd1, 32'd17, 0, 1'b0);
    push(4'd0, 32'hdead, 32'hbeef, 2'd1, 32'd0, 0, 1'b0);
    push(4'd2, 32'd9, 32'd4, 2'd1, 32'd5, 0, 1'b0);
    drain();
    chk("cmd0_reports", rpt_cnt - base, 2);

    // Stray response during CMD
    push(4'd1, $urandom, $urandom, 2'd2, $urandom, 1, 1'b1);
    drain();

    // Random traffic
    repeat (40) begin
      c = 4'($urandom_range(0, 15));
      dly = $urandom_range(0, TIMEOUT + 1);
      if (dly >= TIMEOUT) dly = SILENT;
      push(c, $urandom, $urandom, 2'($urandom_range(1, 3)), $urandom, dly, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 3)) step();
    end
    drain();

    // Reset while waiting with two entries queued
    push(4'd5, $urandom, $urandom, 2'd1, $urandom, SILENT, 1'b0);
    push(4'd6, $urandom, $urandom, 2'd1, $urandom, 0, 1'b0);
    push(4'd7, $urandom, $urandom, 2'd1, $urandom, 0, 1'b0);
    g = 0;
    while (phase != 2 && g < 100) begin step(); g++; end
    chk("reach_wait_bound", g < 100, 1);
    step(); step();
    chk("pre_reset_busy", busy, 1);
    #2 reset = 1'b0;
    #1 chk_reset_outputs("async_reset");
    step();
    reset = 1'b1;
    repeat (20) step();
    chk("after_reset_busy", busy, 0);
    chk("after_reset_ready", txn_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
